// File: rtl/serial_mod_pkg.sv
// Shared helpers for the serial mod-N checker: remainder width, bit-order
// encoding and the legal divisor range.
package serial_mod_pkg;

    localparam logic MODE_MSB = 1'b0;
    localparam logic MODE_LSB = 1'b1;

    localparam int N_MIN = 2;
    localparam int N_MAX = 255;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic bit n_in_range(input int n);
        return (n >= N_MIN) && (n <= N_MAX);
    endfunction

endpackage

// File: rtl/mod_add_n.sv
// Modular adder: sum = (a + b) mod N for operands already reduced below N.
// Latency: purely combinational, one conditional subtraction.
// Backpressure: none, no handshake.
module mod_add_n
    import serial_mod_pkg::*;
#(
    parameter int N  = 3,
    parameter int RW = clog2(N)
) (
    input  logic [RW-1:0] a,
    input  logic [RW-1:0] b,
    output logic [RW-1:0] sum
);

    localparam logic [RW:0] NW = (RW+1)'(N);

    logic [RW:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        if (raw >= NW) begin
            sum = RW'(raw - NW);
        end else begin
            sum = RW'(raw);
        end
    end

endmodule

// File: rtl/serial_mod_n.sv
// Streams a serial number (MSB- or LSB-first) and tracks its value mod N.
// Latency: one cycle from an accepted bit to registered outputs.
// Backpressure: none; din_vld gaps of any length simply hold all state.
module serial_mod_n
    import serial_mod_pkg::*;
#(
    parameter int N  = 3,
    parameter int CW = 16,
    localparam int RW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    input  logic          din_vld,
    input  logic          clr,
    input  logic          lsb_first,
    output logic          dout,
    output logic          dout_vld,
    output logic [RW-1:0] rem,
    output logic [CW-1:0] nbits
);

    if (!n_in_range(N)) begin : g_bad_n
        $error("serial_mod_n: N must lie in 2..255");
    end
    if (CW < 1) begin : g_bad_cw
        $error("serial_mod_n: CW must be at least 1");
    end

    logic          mode_q, mode_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [RW-1:0] pw_q, pw_d;
    logic [CW-1:0] nbits_q, nbits_d;
    logic          dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;

    // clr restarts the frame this cycle, so the arithmetic sees cleared state
    logic          mode_base;
    logic [RW-1:0] rem_base, pw_base;
    logic [CW-1:0] nbits_base;
    logic [RW-1:0] dbl_in, dbl_out;
    logic [RW-1:0] add_a, add_b, add_out;

    // Doubling: rem in MSB mode, the bit weight in LSB mode
    mod_add_n #(.N(N), .RW(RW)) u_dbl (
        .a   (dbl_in),
        .b   (dbl_in),
        .sum (dbl_out)
    );

    mod_add_n #(.N(N), .RW(RW)) u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_out)
    );

    always_comb begin
        mode_base  = clr ? lsb_first : mode_q;
        rem_base   = clr ? '0 : rem_q;
        pw_base    = clr ? RW'(1) : pw_q;
        nbits_base = clr ? '0 : nbits_q;

        dbl_in = (mode_base == MODE_LSB) ? pw_base : rem_base;
        add_a  = (mode_base == MODE_LSB) ? rem_base : dbl_out;
        add_b  = (mode_base == MODE_LSB) ? (din ? pw_base : '0) : RW'(din);

        mode_d     = mode_base;
        rem_d      = rem_base;
        pw_d       = pw_base;
        nbits_d    = nbits_base;
        dout_d     = clr ? 1'b0 : dout_q;
        dout_vld_d = 1'b0;

        if (din_vld) begin
            rem_d = add_out;
            if (mode_base == MODE_LSB) begin
                pw_d = dbl_out;
            end
            if (nbits_base != '1) begin
                nbits_d = nbits_base + CW'(1);
            end
            dout_d     = (add_out == '0);
            dout_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= lsb_first;
            rem_q      <= '0;
            pw_q       <= RW'(1);
            nbits_q    <= '0;
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            rem_q      <= rem_d;
            pw_q       <= pw_d;
            nbits_q    <= nbits_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign rem      = rem_q;
    assign nbits    = nbits_q;

endmodule

// File: tb/tb_serial_mod_n.sv
// Three instances (N=3/CW=3, N=5, N=7) share one stimulus stream; a reference
// model keeps the whole frame as a bit list and evaluates its value mod N.
module tb_serial_mod_n;

    localparam int NDUT = 3;
    localparam int NV [NDUT] = '{3, 5, 7};
    localparam int CV [NDUT] = '{3, 16, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, din, din_vld, clr, lsb_first;

    logic dout_a [NDUT];
    logic dvld_a [NDUT];
    int   rem_a  [NDUT];
    int   nb_a   [NDUT];

    genvar g;
    for (g = 0; g < NDUT; g++) begin : g_dut
        localparam int RWG = $clog2(NV[g]);
        logic [RWG-1:0]   r;
        logic [CV[g]-1:0] nb;
        logic             dq, dv;

        serial_mod_n #(.N(NV[g]), .CW(CV[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .din       (din),
            .din_vld   (din_vld),
            .clr       (clr),
            .lsb_first (lsb_first),
            .dout      (dq),
            .dout_vld  (dv),
            .rem       (r),
            .nbits     (nb)
        );

        assign dout_a[g] = dq;
        assign dvld_a[g] = dv;
        assign rem_a[g]  = int'(r);
        assign nb_a[g]   = int'(nb);
    end

    typedef struct {
        bit dout;
        int rem;
        int nb;
    } exp_t;

    exp_t sbq [NDUT][$];
    exp_t cur [NDUT];
    bit   frame[$];
    bit   mode;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Value of the received bit string mod n, honouring the frame's bit order
    function automatic int frame_mod(input int n);
        int v;
        v = 0;
        if (!mode) begin
            for (int i = 0; i < frame.size(); i++) v = (v * 2 + int'(frame[i])) % n;
        end else begin
            for (int i = frame.size() - 1; i >= 0; i--) v = (v * 2 + int'(frame[i])) % n;
        end
        return v;
    endfunction

    task automatic cmp(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d(N=%0d): got %0d expected %0d at %0t",
                     nm, d, NV[d], act, exp, $time);
        end
    endtask

    // Reference model: evaluates the inputs seen at each rising edge
    always @(posedge clk) begin
        if (rst) begin
            frame.delete();
            mode = lsb_first;
            for (int d = 0; d < NDUT; d++) begin
                cur[d].dout = 1'b0;
                cur[d].rem  = 0;
                cur[d].nb   = 0;
            end
            mon_en = 1'b1;
        end else begin
            if (clr) begin
                frame.delete();
                mode = lsb_first;
                for (int d = 0; d < NDUT; d++) cur[d].dout = 1'b0;
            end
            if (din_vld) frame.push_back(din);
            for (int d = 0; d < NDUT; d++) begin
                int sat;
                sat = (1 << CV[d]) - 1;
                cur[d].rem = frame_mod(NV[d]);
                cur[d].nb  = (frame.size() > sat) ? sat : frame.size();
                if (din_vld) begin
                    cur[d].dout = (cur[d].rem == 0);
                    sbq[d].push_back(cur[d]);
                end
            end
        end
    end

    // Monitor: pops on every strobe, otherwise checks that outputs hold
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < NDUT; d++) begin
                exp_t e;
                if (dvld_a[d]) begin
                    if (sbq[d].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_strobe dut%0d(N=%0d): got dout_vld 1 expected 0 at %0t",
                                 d, NV[d], $time);
                    end else begin
                        e = sbq[d].pop_front();
                        cmp("rem", d, rem_a[d], e.rem);
                        cmp("nbits", d, nb_a[d], e.nb);
                        cmp("dout", d, int'(dout_a[d]), int'(e.dout));
                    end
                end else begin
                    cmp("missed_strobe", d, sbq[d].size(), 0);
                    sbq[d].delete();
                    cmp("hold_rem", d, rem_a[d], cur[d].rem);
                    cmp("hold_nbits", d, nb_a[d], cur[d].nb);
                    cmp("hold_dout", d, int'(dout_a[d]), int'(cur[d].dout));
                end
            end
        end
    end

    task automatic step(input bit r, input bit c, input bit v, input bit b, input bit l);
        @(negedge clk);
        rst       = r;
        clr       = c;
        din_vld   = v;
        din       = b;
        lsb_first = l;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; din_vld = 1'b0; din = 1'b0; lsb_first = 1'b0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // MSB-first 1,0,1,0
        step(0, 0, 1, 1, 0); step(0, 0, 1, 0, 0); step(0, 0, 1, 1, 0); step(0, 0, 1, 0, 0);

        // New frame 1,1,<gap 3>,1
        step(0, 1, 1, 1, 0); step(0, 0, 1, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);

        // LSB-first 1,1,0,1 with lsb_first wiggling mid-frame
        step(0, 1, 1, 1, 1); step(0, 0, 1, 1, 0); step(0, 0, 1, 0, 1); step(0, 0, 1, 1, 0);

        // Mid-frame clr with a bit, switching to LSB mode
        step(0, 1, 0, 0, 0); step(0, 0, 1, 1, 0); step(0, 0, 1, 1, 1);
        step(0, 1, 1, 1, 1); step(0, 0, 1, 1, 0); step(0, 0, 1, 0, 0); step(0, 0, 1, 1, 1);

        // clr alone, then idle
        step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 1);

        // rst mid-frame with a bit present
        step(0, 0, 1, 1, 0); step(0, 0, 1, 0, 0); step(1, 0, 1, 1, 0); step(0, 0, 0, 0, 0);

        // Nine zero bits: saturates the CW=3 counter
        step(0, 1, 1, 0, 0);
        repeat (8) step(0, 0, 1, 0, 0);

        // rst beats clr and din_vld
        step(1, 1, 1, 1, 1); step(0, 0, 1, 1, 0);

        repeat (4000) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 7,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        repeat (3) step(0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) cmp("drain", d, sbq[d].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
